ibex_wb_pipe: RTL and testbench

// - Writeback stage directly downstream of the execution block: captures the EX result (ALU/multdiv/IPM

---
 rtl/ibex_wb_pipe.sv | 160 ++++++++++++++++
 tb/tb_ibex_wb_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_wb_pipe.sv
// ibex_wb_pipe
// Writeback stage directly downstream of EX. It holds one instruction, captures
// the EX result or waits for the LSU response, and drives the single
// register-file write port. It also provides ID with a forwarding path from the
// held EX result, and pulses instr_done_wb_o once per retired instruction.
//
// Ports
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   en_wb_i                   ID/EX offers an instruction (taken when ready_wb_o=1)
//   instr_type_wb_i [1:0]     00 reg-result, 01 load, 10 store, 11 treated as 00
//   rf_we_id_i                instruction writes a register
//   rf_waddr_id_i [4:0]       destination register
//   rf_wdata_id_i [31:0]      EX result, sampled on accept
//   lsu_resp_valid_i          LSU response for the held load/store
//   lsu_resp_err_i            LSU response carries a bus error
//   rf_wdata_lsu_i [31:0]     load data, valid with lsu_resp_valid_i
//   ready_wb_o                WB can accept en_wb_i this cycle
//   rf_we_wb_o, rf_waddr_wb_o, rf_wdata_wb_o   register-file write port
//   fwd_valid_wb_o, rf_wdata_fwd_wb_o          forwarding of held EX result
//   outstanding_load_wb_o     waiting on a load response
//   instr_done_wb_o           one-cycle pulse per retired instruction
//   lsu_resp_spurious_o       LSU response arrived with no load/store held

module ibex_wb_pipe #(
  parameter bit ResetAll  = 1'b0,
  parameter bit ForwardEn = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_wb_i,
  input  logic [1:0]  instr_type_wb_i,
  input  logic        rf_we_id_i,
  input  logic [4:0]  rf_waddr_id_i,
  input  logic [31:0] rf_wdata_id_i,
  input  logic        lsu_resp_valid_i,
  input  logic        lsu_resp_err_i,
  input  logic [31:0] rf_wdata_lsu_i,
  output logic        ready_wb_o,
  output logic        rf_we_wb_o,
  output logic [4:0]  rf_waddr_wb_o,
  output logic [31:0] rf_wdata_wb_o,
  output logic        fwd_valid_wb_o,
  output logic [31:0] rf_wdata_fwd_wb_o,
  output logic        outstanding_load_wb_o,
  output logic        instr_done_wb_o,
  output logic        lsu_resp_spurious_o
);

  typedef enum logic [1:0] {
    WB_EMPTY = 2'd0,
    WB_REG   = 2'd1,
    WB_LOAD  = 2'd2,
    WB_STORE = 2'd3
  } wb_state_e;

  wb_state_e   state_q, state_d;
  logic        rf_we_q;
  logic [4:0]  waddr_q;
  logic [31:0] wdata_q;

  logic        lsu_state;
  logic        done;
  logic        accept;

  assign lsu_state = (state_q == WB_LOAD) || (state_q == WB_STORE);
  assign done      = (state_q == WB_REG) || (lsu_state && lsu_resp_valid_i);
  assign accept    = en_wb_i && ready_wb_o;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= WB_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a new instruction overrides retirement so done+accept
  // moves straight into the new instruction's state without a bubble.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      unique case (instr_type_wb_i)
        2'b01:   state_d = WB_LOAD;
        2'b10:   state_d = WB_STORE;
        default: state_d = WB_REG;
      endcase
    end else if (done) begin
      state_d = WB_EMPTY;
    end
  end

  // Write-enable is control state, so it is always reset. Writes to x0 are
  // squashed here once instead of at every use.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_q <= 1'b0;
    end else if (accept) begin
      rf_we_q <= rf_we_id_i && (rf_waddr_id_i != 5'd0);
    end
  end

  // Address/data registers only carry a reset when ResetAll asks for it.
  if (ResetAll) begin : g_data_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        waddr_q <= 5'd0;
        wdata_q <= 32'd0;
      end else if (accept) begin
        waddr_q <= rf_waddr_id_i;
        wdata_q <= rf_wdata_id_i;
      end
    end
  end else begin : g_data_norst
    always_ff @(posedge clk_i) begin
      if (accept) begin
        waddr_q <= rf_waddr_id_i;
        wdata_q <= rf_wdata_id_i;
      end
    end
  end

  // Outputs. Load data passes straight through in the response cycle and
  // is never forwarded; ID stalls on outstanding_load_wb_o instead.
  always_comb begin
    ready_wb_o            = (state_q == WB_EMPTY) || done;
    rf_we_wb_o            = 1'b0;
    rf_waddr_wb_o         = waddr_q;
    rf_wdata_wb_o         = wdata_q;
    fwd_valid_wb_o        = 1'b0;
    rf_wdata_fwd_wb_o     = wdata_q;
    outstanding_load_wb_o = 1'b0;
    instr_done_wb_o       = done;
    lsu_resp_spurious_o   = lsu_resp_valid_i && !lsu_state;
    unique case (state_q)
      WB_EMPTY: begin
        if (ResetAll) begin
          rf_waddr_wb_o = 5'd0;
          rf_wdata_wb_o = 32'd0;
        end
      end
      WB_REG: begin
        rf_we_wb_o     = rf_we_q;
        fwd_valid_wb_o = ForwardEn && rf_we_q;
      end
      WB_LOAD: begin
        rf_we_wb_o            = lsu_resp_valid_i && rf_we_q && !lsu_resp_err_i;
        rf_wdata_wb_o         = rf_wdata_lsu_i;
        outstanding_load_wb_o = 1'b1;
      end
      WB_STORE: begin
        rf_we_wb_o = 1'b0;
      end
      default: begin
        rf_we_wb_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ibex_wb_pipe.sv
// tb_ibex_wb_pipe
// Directed testbench for ibex_wb_pipe with default parameters. Inputs change
// 1ns after the rising edge; outputs are checked 2ns later, well before the
// next rising edge.

module tb_ibex_wb_pipe;

  logic        clk;
  logic        rst_n;
  logic        en_wb;
  logic [1:0]  instr_type;
  logic        rf_we_id;
  logic [4:0]  rf_waddr_id;
  logic [31:0] rf_wdata_id;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] lsu_data;
  logic        ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_valid;
  logic [31:0] fwd_data;
  logic        outstanding;
  logic        done;
  logic        spurious;

  int numCompared   = 0;
  int numMismatched = 0;

  ibex_wb_pipe dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .en_wb_i               (en_wb),
    .instr_type_wb_i       (instr_type),
    .rf_we_id_i            (rf_we_id),
    .rf_waddr_id_i         (rf_waddr_id),
    .rf_wdata_id_i         (rf_wdata_id),
    .lsu_resp_valid_i      (resp_valid),
    .lsu_resp_err_i        (resp_err),
    .rf_wdata_lsu_i        (lsu_data),
    .ready_wb_o            (ready),
    .rf_we_wb_o            (rf_we),
    .rf_waddr_wb_o         (rf_waddr),
    .rf_wdata_wb_o         (rf_wdata),
    .fwd_valid_wb_o        (fwd_valid),
    .rf_wdata_fwd_wb_o     (fwd_data),
    .outstanding_load_wb_o (outstanding),
    .instr_done_wb_o       (done),
    .lsu_resp_spurious_o   (spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's worth of inputs and let combinational outputs settle
  task automatic applyStimulus(input logic en, input logic [1:0] typ, input logic we,
                               input logic [4:0] waddr, input logic [31:0] wdata,
                               input logic rv, input logic re, input logic [31:0] ld);
    en_wb       = en;
    instr_type  = typ;
    rf_we_id    = we;
    rf_waddr_id = waddr;
    rf_wdata_id = wdata;
    resp_valid  = rv;
    resp_err    = re;
    lsu_data    = ld;
    #2;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 2'b00, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    checkOutput("rst_ready", ready, 1);
    checkOutput("rst_rf_we", rf_we, 0);
    checkOutput("rst_fwd_valid", fwd_valid, 0);
    checkOutput("rst_outstanding", outstanding, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_spurious", spurious, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single REG instruction, latency one
    applyStimulus(1'b1, 2'b00, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0);
    checkOutput("reg_accept_ready", ready, 1);
    checkOutput("reg_accept_done", done, 0);
    tick();
    idle();
    checkOutput("reg_we", rf_we, 1);
    checkOutput("reg_waddr", rf_waddr, 5);
    checkOutput("reg_wdata", rf_wdata, 32'hDEADBEEF);
    checkOutput("reg_fwd_valid", fwd_valid, 1);
    checkOutput("reg_fwd_data", fwd_data, 32'hDEADBEEF);
    checkOutput("reg_done", done, 1);
    tick();
    idle();
    checkOutput("reg_after_done", done, 0);
    checkOutput("reg_after_we", rf_we, 0);

    // Back-to-back REG x5=1, x6=2, x7=3
    applyStimulus(1'b1, 2'b00, 1'b1, 5'd5, 32'd1, 1'b0, 1'b0, 32'd0);
    checkOutput("b2b_ready0", ready, 1);
    tick();
    applyStimulus(1'b1, 2'b00, 1'b1, 5'd6, 32'd2, 1'b0, 1'b0, 32'd0);
    checkOutput("b2b_ready1", ready, 1);
    checkOutput("b2b_waddr1", rf_waddr, 5);
    checkOutput("b2b_wdata1", rf_wdata, 1);
    checkOutput("b2b_we1", rf_we, 1);
    tick();
    applyStimulus(1'b1, 2'b00, 1'b1, 5'd7, 32'd3, 1'b0, 1'b0, 32'd0);
    checkOutput("b2b_ready2", ready, 1);
    checkOutput("b2b_waddr2", rf_waddr, 6);
    checkOutput("b2b_wdata2", rf_wdata, 2);
    tick();
    idle();
    checkOutput("b2b_waddr3", rf_waddr, 7);
    checkOutput("b2b_wdata3", rf_wdata, 3);
    checkOutput("b2b_done3", done, 1);
    tick();
    idle();
    checkOutput("b2b_idle_done", done, 0);

    // Load x8, response after three wait cycles
    applyStimulus(1'b1, 2'b01, 1'b1, 5'd8, 32'h0000AAAA, 1'b0, 1'b0, 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      idle();
      checkOutput($sformatf("ld_wait%0d_outstanding", i), outstanding, 1);
      checkOutput($sformatf("ld_wait%0d_ready", i), ready, 0);
      checkOutput($sformatf("ld_wait%0d_we", i), rf_we, 0);
      checkOutput($sformatf("ld_wait%0d_fwd", i), fwd_valid, 0);
      tick();
    end
    applyStimulus(1'b0, 2'b00, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 32'h12345678);
    checkOutput("ld_resp_we", rf_we, 1);
    checkOutput("ld_resp_waddr", rf_waddr, 8);
    checkOutput("ld_resp_wdata", rf_wdata, 32'h12345678);
    checkOutput("ld_resp_done", done, 1);
    checkOutput("ld_resp_ready", ready, 1);
    checkOutput("ld_resp_fwd", fwd_valid, 0);
    checkOutput("ld_resp_spurious", spurious, 0);
    tick();
    idle();
    checkOutput("ld_after_outstanding", outstanding, 0);
    checkOutput("ld_after_done", done, 0);

    // Load with bus error: retires, no write
    applyStimulus(1'b1, 2'b01, 1'b1, 5'd10, 32'd0, 1'b0, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 2'b00, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 32'hFFFFFFFF);
    checkOutput("ld_err_done", done, 1);
    checkOutput("ld_err_we", rf_we, 0);
    tick();
    idle();
    checkOutput("ld_err_after_outstanding", outstanding, 0);

    // Store: waits for response, never writes
    applyStimulus(1'b1, 2'b10, 1'b1, 5'd11, 32'd0, 1'b0, 1'b0, 32'd0);
    tick();
    idle();
    checkOutput("st_wait_ready", ready, 0);
    checkOutput("st_wait_outstanding", outstanding, 0);
    checkOutput("st_wait_done", done, 0);
    tick();
    applyStimulus(1'b0, 2'b00, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 32'd0);
    checkOutput("st_resp_done", done, 1);
    checkOutput("st_resp_we", rf_we, 0);
    checkOutput("st_resp_spurious", spurious, 0);
    tick();

    // REG to x0: retires without writing or forwarding
    applyStimulus(1'b1, 2'b00, 1'b1, 5'd0, 32'h55, 1'b0, 1'b0, 32'd0);
    tick();
    idle();
    checkOutput("x0_done", done, 1);
    checkOutput("x0_we", rf_we, 0);
    checkOutput("x0_fwd", fwd_valid, 0);
    tick();

    // Reserved type behaves as REG
    applyStimulus(1'b1, 2'b11, 1'b1, 5'd12, 32'h0C, 1'b0, 1'b0, 32'd0);
    tick();
    idle();
    checkOutput("rsv_we", rf_we, 1);
    checkOutput("rsv_waddr", rf_waddr, 12);
    checkOutput("rsv_done", done, 1);
    checkOutput("rsv_outstanding", outstanding, 0);
    tick();

    // Offer held while a store is pending; accepted in the response cycle
    applyStimulus(1'b1, 2'b10, 1'b0, 5'd13, 32'd0, 1'b0, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b1, 2'b00, 1'b1, 5'd14, 32'h0E, 1'b0, 1'b0, 32'd0);
    checkOutput("hold_ready0", ready, 0);
    tick();
    applyStimulus(1'b1, 2'b00, 1'b1, 5'd14, 32'h0E, 1'b0, 1'b0, 32'd0);
    checkOutput("hold_ready1", ready, 0);
    checkOutput("hold_done1", done, 0);
    tick();
    applyStimulus(1'b1, 2'b00, 1'b1, 5'd14, 32'h0E, 1'b1, 1'b0, 32'd0);
    checkOutput("hold_resp_ready", ready, 1);
    checkOutput("hold_resp_done", done, 1);
    tick();
    idle();
    checkOutput("hold_reg_we", rf_we, 1);
    checkOutput("hold_reg_waddr", rf_waddr, 14);
    checkOutput("hold_reg_wdata", rf_wdata, 32'h0E);
    checkOutput("hold_reg_done", done, 1);
    tick();

    // Spurious response while empty
    applyStimulus(1'b0, 2'b00, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 32'h0BAD0BAD);
    checkOutput("spur_flag", spurious, 1);
    checkOutput("spur_done", done, 0);
    checkOutput("spur_we", rf_we, 0);
    tick();
    idle();
    checkOutput("spur_after_flag", spurious, 0);
    checkOutput("spur_after_ready", ready, 1);
    checkOutput("spur_after_outstanding", outstanding, 0);

    // Reset asserted while a load is outstanding
    applyStimulus(1'b1, 2'b01, 1'b1, 5'd15, 32'd0, 1'b0, 1'b0, 32'd0);
    tick();
    idle();
    checkOutput("rstld_outstanding", outstanding, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstld_outstanding_rst", outstanding, 0);
    checkOutput("rstld_ready_rst", ready, 1);
    checkOutput("rstld_we_rst", rf_we, 0);
    checkOutput("rstld_done_rst", done, 0);
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(1'b0, 2'b00, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 32'h11111111);
    checkOutput("rstld_late_spurious", spurious, 1);
    checkOutput("rstld_late_done", done, 0);
    checkOutput("rstld_late_we", rf_we, 0);
    tick();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
